// File: rtl/banked_register_file.sv
// Parametrised register file: three combinational read ports, one write port,
// PC register with load/stall, and a pending-write scoreboard. Optional
// write-through forwarding is enabled by defining BANKED_RF_BYPASS_EN.
module banked_register_file #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       PC_IDX   = 15,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  input  logic [ADDR_W-1:0] SD,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PD,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              PC_LD,
  input  logic [DATA_W-1:0] PC_IN,
  output logic [DATA_W-1:0] PC_OUT,
  input  logic              RSV,
  input  logic [ADDR_W-1:0] RSV_A,
  output logic              BUSY_A,
  output logic              BUSY_B,
  output logic              BUSY_D,
  output logic [ADDR_W:0]   BUSY_CNT
);

  localparam int unsigned       NREGS   = 2 ** ADDR_W;
  localparam int unsigned       CNT_W   = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_nxt;
  logic [DATA_W-1:0] pc_nxt;
  logic              fwd_a;
  logic              fwd_b;
  logic              fwd_d;

  // PC priority: write-back branch beats sequential load; otherwise stall
  always_comb begin
    pc_nxt = regs[PC_ADDR];
    if (WE && (WA == PC_ADDR)) begin
      pc_nxt = WD;
    end else if (PC_LD) begin
      pc_nxt = PC_IN;
    end
  end

  // Scoreboard: a fresh reservation wins over a same-address retire
  always_comb begin
    busy_nxt = busy;
    if (WE) begin
      busy_nxt[WA] = 1'b0;
    end
    if (RSV) begin
      busy_nxt[RSV_A] = 1'b1;
    end
    busy_cnt_nxt = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_cnt_nxt = busy_cnt_nxt + CNT_W'(busy_nxt[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= (i == PC_IDX) ? PC_RESET : '0;
      end
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (WE && (WA != PC_ADDR)) begin
        regs[WA] <= WD;
      end
      regs[PC_ADDR] <= pc_nxt;
      busy          <= busy_nxt;
      busy_cnt_q    <= busy_cnt_nxt;
    end
  end

`ifdef BANKED_RF_BYPASS_EN
  assign fwd_a = WE && (WA == SA);
  assign fwd_b = WE && (WA == SB);
  assign fwd_d = WE && (WA == SD);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
  assign fwd_d = 1'b0;
`endif

  // A forwarded port sees the hazard resolved this cycle
  assign PA       = fwd_a ? WD : regs[SA];
  assign PB       = fwd_b ? WD : regs[SB];
  assign PD       = fwd_d ? WD : regs[SD];
  assign BUSY_A   = busy[SA] & ~fwd_a;
  assign BUSY_B   = busy[SB] & ~fwd_b;
  assign BUSY_D   = busy[SD] & ~fwd_d;
  assign PC_OUT   = regs[PC_ADDR];
  assign BUSY_CNT = busy_cnt_q;

endmodule

// File: tb/tb_banked_register_file.sv
// Bench for banked_register_file: directed vector table, hand-written
// scoreboard saturation sequence, and randomized run against a reference model.
module tb_banked_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 16;
  localparam int unsigned PCI = 15;

`ifdef BANKED_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] SA, SB, SD, WA, RSV_A;
  logic [DW-1:0] PA, PB, PD, WD, PC_IN, PC_OUT;
  logic          WE, PC_LD, RSV, BUSY_A, BUSY_B, BUSY_D;
  logic [AW:0]   BUSY_CNT;

  int checks = 0;
  int failures = 0;

  banked_register_file dut (
    .CLK(CLK), .RST(RST), .SA(SA), .SB(SB), .SD(SD), .PA(PA), .PB(PB), .PD(PD),
    .WE(WE), .WA(WA), .WD(WD), .PC_LD(PC_LD), .PC_IN(PC_IN), .PC_OUT(PC_OUT),
    .RSV(RSV), .RSV_A(RSV_A), .BUSY_A(BUSY_A), .BUSY_B(BUSY_B), .BUSY_D(BUSY_D),
    .BUSY_CNT(BUSY_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst; logic we; logic [3:0] wa; logic [31:0] wd;
    logic pl; logic [31:0] pi; logic rsv; logic [3:0] ra;
    logic [3:0] sa; logic [3:0] sb; logic [3:0] sd;
    logic chk;
    logic [31:0] pa; logic [31:0] pb; logic [31:0] pd; logic [31:0] pc;
    logic ba; logic [4:0] cnt;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic we, input logic [3:0] wa,
                             input logic [31:0] wd, input logic pl, input logic [31:0] pi,
                             input logic rsv, input logic [3:0] ra, input logic [3:0] sa,
                             input logic [3:0] sb, input logic [3:0] sd, input logic chk,
                             input logic [31:0] pa, input logic [31:0] pb,
                             input logic [31:0] pd, input logic [31:0] pc,
                             input logic ba, input logic [4:0] cnt);
    vec_t r;
    r.rst = rst; r.we = we; r.wa = wa; r.wd = wd; r.pl = pl; r.pi = pi;
    r.rsv = rsv; r.ra = ra; r.sa = sa; r.sb = sb; r.sd = sd; r.chk = chk;
    r.pa = pa; r.pb = pb; r.pd = pd; r.pc = pc; r.ba = ba; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic pl, input logic [31:0] pi,
                       input logic rsv, input logic [3:0] ra, input logic [3:0] sa,
                       input logic [3:0] sb, input logic [3:0] sd);
    RST = rst; WE = we; WA = wa; WD = wd; PC_LD = pl; PC_IN = pi;
    RSV = rsv; RSV_A = ra; SA = sa; SB = sb; SD = sd;
  endtask

  // Reference model state
  logic [31:0] m_regs [NR];
  bit          m_busy [NR];
  int          m_cnt;

  task automatic model_edge(input logic rst, input logic we, input logic [3:0] wa,
                            input logic [31:0] wd, input logic pl, input logic [31:0] pi,
                            input logic rsv, input logic [3:0] ra);
    int net;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_cnt = 0;
      return;
    end
    net = 0;
    if (rsv && !m_busy[ra]) net = net + 1;
    if (we && m_busy[wa] && !(rsv && ra == wa)) net = net - 1;
    m_cnt = m_cnt + net;
    if (m_cnt > int'(NR)) m_cnt = int'(NR);
    if (m_cnt < 0) m_cnt = 0;
    if (we) m_busy[wa] = 1'b0;
    if (rsv) m_busy[ra] = 1'b1;
    if (we && wa == 4'(PCI)) m_regs[PCI] = wd;
    else if (pl) m_regs[PCI] = pi;
    if (we && wa != 4'(PCI)) m_regs[wa] = wd;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] s, input logic we,
                                         input logic [3:0] wa, input logic [31:0] wd);
    return (BYP && we && wa == s) ? wd : m_regs[s];
  endfunction

  function automatic logic m_bsy(input logic [3:0] s, input logic we, input logic [3:0] wa);
    return (BYP && we && wa == s) ? 1'b0 : logic'(m_busy[s]);
  endfunction

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst we wa wd pl pi rsv ra sa sb sd chk pa pb pd pc ba cnt
    vecs.push_back(v(1,0, 0, 0, 0,  0, 0,0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0));
    vecs.push_back(v(0,0, 0, 0, 1,  4, 0,0, 0, 5,15, 1,  0,  0,  0,  0, 0,0));
    vecs.push_back(v(0,0, 0, 0, 1,  8, 0,0, 0, 5,15, 1,  0,  0,  4,  4, 0,0));
    vecs.push_back(v(0,0, 0, 0, 1, 12, 0,0, 0, 5,15, 1,  0,  0,  8,  8, 0,0));
    vecs.push_back(v(0,0, 0, 0, 0,  0, 0,0, 0, 5,15, 1,  0,  0, 12, 12, 0,0));
    vecs.push_back(v(0,1, 3,90, 0,  0, 0,0, 0, 0, 0, 1,  0,  0,  0, 12, 0,0));
    vecs.push_back(v(0,1,10, 9, 0,  0, 0,0, 3, 3, 3, 1, 90, 90, 90, 12, 0,0));
    vecs.push_back(v(0,1,10,16, 0,  0, 0,0, 3,10,15, 1, 90, BYP ? 32'd16 : 32'd9, 12, 12, 0,0));
    vecs.push_back(v(0,1,15,35, 1,100, 0,0,10, 3, 3, 1, 16, 90, 90, 12, 0,0));
    vecs.push_back(v(0,0, 0, 0, 1,100, 0,0,10, 3,15, 1, 16, 90, 35, 35, 0,0));
    vecs.push_back(v(0,0, 0, 0, 0,  0, 1,5, 5, 0,15, 1,  0,  0,100,100, 0,0));
    vecs.push_back(v(0,1, 5, 7, 0,  0, 1,5, 0, 0,15, 1,  0,  0,100,100, 0,1));
    vecs.push_back(v(0,0, 0, 0, 0,  0, 0,0, 5, 0,15, 1,  7,  0,100,100, 1,1));
    vecs.push_back(v(0,1, 5, 8, 0,  0, 0,0, 0, 0,15, 1,  0,  0,100,100, 0,1));
    vecs.push_back(v(0,0, 0, 0, 0,  0, 0,0, 5, 0,15, 1,  8,  0,100,100, 0,0));
    vecs.push_back(v(0,1, 4,73, 0,  0, 1,1, 0, 0,15, 1,  0,  0,100,100, 0,0));
    vecs.push_back(v(0,0, 0, 0, 0,  0, 1,2, 1, 0,15, 1,  0,  0,100,100, 1,1));
    vecs.push_back(v(0,0, 0, 0, 0,  0, 1,7, 4, 0,15, 1, 73,  0,100,100, 0,2));
    vecs.push_back(v(1,1, 4,99, 1, 55, 1,9, 7, 4,15, 1,  0, BYP ? 32'd99 : 32'd73, 100, 100, 1,3));
    vecs.push_back(v(0,0, 0, 0, 0,  0, 0,0, 4, 5,15, 1,  0,  0,  0,  0, 0,0));
    vecs.push_back(v(0,1, 6,50, 0,  0, 0,0, 6, 0,15, 1, BYP ? 32'd50 : 32'd0, 0, 0, 0, 0,0));
    vecs.push_back(v(0,0, 0, 0, 0,  0, 0,0, 6, 0,15, 1, 50,  0,  0,  0, 0,0));

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].pl, vecs[i].pi,
            vecs[i].rsv, vecs[i].ra, vecs[i].sa, vecs[i].sb, vecs[i].sd);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_pa", i), PA, vecs[i].pa);
        check($sformatf("vec%0d_pb", i), PB, vecs[i].pb);
        check($sformatf("vec%0d_pd", i), PD, vecs[i].pd);
        check($sformatf("vec%0d_pc", i), PC_OUT, vecs[i].pc);
        check($sformatf("vec%0d_busy_a", i), 32'(BUSY_A), 32'(vecs[i].ba));
        check($sformatf("vec%0d_busy_cnt", i), 32'(BUSY_CNT), 32'(vecs[i].cnt));
      end
    end

    // Saturation: reserve every register, then re-reserve one
    @(negedge CLK); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < int'(NR); i++) begin
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 1, 4'(i), 0, 0, 0);
    end
    @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 9, 15); #1;
    check("sat_full_cnt", 32'(BUSY_CNT), 32'd16);
    check("sat_busy_d_pc", 32'(BUSY_D), 32'd1);
    @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 9, 15); #1;
    check("sat_rereserve_cnt", 32'(BUSY_CNT), 32'd16);
    check("sat_busy_a", 32'(BUSY_A), 32'd1);
    @(negedge CLK); drive(0, 1, 3, 11, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0); #1;
    check("sat_retire_cnt", 32'(BUSY_CNT), 32'd15);
    check("sat_retire_busy", 32'(BUSY_A), 32'd0);
    check("sat_retire_data", PA, 32'd11);
    // Write to a non-busy register must not underflow the count
    @(negedge CLK); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); drive(0, 1, 2, 5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0); #1;
    check("underflow_cnt", 32'(BUSY_CNT), 32'd0);
    check("underflow_busy_b", 32'(BUSY_B), 32'd0);
    check("underflow_data", PB, 32'd5);

    // Randomized run against the reference model
    @(negedge CLK); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_edge(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic rst, we, pl, rsv;
      logic [3:0] wa, ra, sa, sb, sd;
      logic [31:0] wd, pi;
      @(negedge CLK);
      rst = ($urandom_range(0, 39) == 0);
      we  = 1'($urandom);
      pl  = 1'($urandom);
      rsv = ($urandom_range(0, 2) != 0);
      wa  = 4'($urandom);
      ra  = 4'($urandom);
      sa  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      sb  = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom);
      sd  = ($urandom_range(0, 5) == 0) ? 4'(PCI) : 4'($urandom);
      wd  = $urandom;
      pi  = $urandom;
      drive(rst, we, wa, wd, pl, pi, rsv, ra, sa, sb, sd);
      #1;
      check("rnd_pa", PA, m_read(sa, we, wa, wd));
      check("rnd_pb", PB, m_read(sb, we, wa, wd));
      check("rnd_pd", PD, m_read(sd, we, wa, wd));
      check("rnd_pc", PC_OUT, m_regs[PCI]);
      check("rnd_busy_a", 32'(BUSY_A), 32'(m_bsy(sa, we, wa)));
      check("rnd_busy_b", 32'(BUSY_B), 32'(m_bsy(sb, we, wa)));
      check("rnd_busy_d", 32'(BUSY_D), 32'(m_bsy(sd, we, wa)));
      check("rnd_busy_cnt", 32'(BUSY_CNT), 32'(m_cnt));
      model_edge(rst, we, wa, wd, pl, pi, rsv, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
